// File: rtl/spi_pkg.sv
// Shared types for the SPI slave: mode encoding and FSM state enum.
package spi_pkg;

    // {CPOL, CPHA} as presented on the mode port; cpol is the MSB.
    typedef struct packed {
        logic cpol;
        logic cpha;
    } spi_mode_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } spi_slave_state_t;

endpackage

// File: rtl/spi_sync.sv
// Single-bit multi-flop synchroniser with a selectable reset level.
module spi_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    // Shift the asynchronous input through the flop chain; reset parks it at RESET_VAL.
    always_ff @(posedge clk) begin
        if (!rst) begin
            chain <= {STAGES{RESET_VAL}};
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/spi_slave.sv
// SPI slave, all four modes, oversampled on clk with a single-entry tx buffer.
//
// state  | meaning
// IDLE   | deselected; waiting for a cs_n falling edge
// ACTIVE | selected; sampling mosi and shifting miso on sclk edges
// DONE   | one clk after the last sample: publish rx_data, reload next frame
module spi_slave import spi_pkg::*; #(
    parameter int SYNC_STAGES = 2,
    parameter int DATA_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            mode,
    input  logic                  sclk,
    input  logic                  cs_n,
    input  logic                  mosi,
    output logic                  miso,
    output logic                  miso_oe,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  overrun
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    logic sclk_s, cs_s, mosi_s;
    logic sclk_d, cs_d;

    spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst(rst), .d(sclk), .q(sclk_s)
    );
    spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
        .clk(clk), .rst(rst), .d(cs_n), .q(cs_s)
    );
    spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst(rst), .d(mosi), .q(mosi_s)
    );

    spi_slave_state_t      state;
    spi_mode_t             mode_q;
    logic [DATA_WIDTH-1:0] tx_shift;
    logic [DATA_WIDTH-1:0] rx_shift;
    logic [CNT_W-1:0]      bit_cnt;
    logic                  shift_pend;
    logic                  miso_r;
    logic [DATA_WIDTH-1:0] tx_buf;
    logic                  tx_full;

    logic sclk_edge, lead_edge, trail_edge, sample_edge, shift_edge;
    logic cs_fall, cs_rise, load, accept;
    logic [DATA_WIDTH-1:0] load_val;

    // One-flop delayed copies of the synchronised strobes for edge detection.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sclk_d <= 1'b0;
            cs_d   <= 1'b1;
        end else begin
            sclk_d <= sclk_s;
            cs_d   <= cs_s;
        end
    end

    assign sclk_edge   = sclk_s ^ sclk_d;
    assign lead_edge   = sclk_edge && (sclk_s != mode_q.cpol);
    assign trail_edge  = sclk_edge && (sclk_s == mode_q.cpol);
    assign sample_edge = mode_q.cpha ? trail_edge : lead_edge;
    assign shift_edge  = mode_q.cpha ? lead_edge  : trail_edge;
    assign cs_fall     = cs_d & ~cs_s;
    assign cs_rise     = ~cs_d & cs_s;

    assign load     = ((state == IDLE) && cs_fall) || ((state == DONE) && !cs_s);
    assign load_val = tx_full ? tx_buf : '0;
    assign accept   = tx_valid && !tx_full;

    // Frame sequencing: load, sample/shift, publish, and deselect handling.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            mode_q     <= '0;
            tx_shift   <= '0;
            rx_shift   <= '0;
            bit_cnt    <= '0;
            shift_pend <= 1'b0;
            miso_r     <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (cs_s) begin
                mode_q <= spi_mode_t'(mode);
            end
            case (state)
                IDLE: begin
                    if (cs_fall) begin
                        state      <= ACTIVE;
                        tx_shift   <= load_val;
                        miso_r     <= load_val[DATA_WIDTH-1];
                        bit_cnt    <= '0;
                        shift_pend <= 1'b0;
                        if (!tx_full) overrun <= 1'b1;
                    end
                end
                ACTIVE: begin
                    if (sample_edge) begin
                        rx_shift   <= {rx_shift[DATA_WIDTH-2:0], mosi_s};
                        shift_pend <= 1'b1;
                        // The final sample wins over a simultaneous deselect.
                        if (bit_cnt == LAST_BIT) begin
                            state <= DONE;
                        end else begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                            if (cs_rise) state <= IDLE;
                        end
                    end else if (cs_rise) begin
                        state <= IDLE;
                    end
                    // CPHA=0 ignores the trailing edge after the last bit, which
                    // would otherwise shift away the freshly reloaded MSB.
                    if (shift_edge && (mode_q.cpha || shift_pend)) begin
                        tx_shift   <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
                        miso_r     <= mode_q.cpha ? tx_shift[DATA_WIDTH-1]
                                                  : tx_shift[DATA_WIDTH-2];
                        shift_pend <= 1'b0;
                    end
                end
                DONE: begin
                    rx_data    <= rx_shift;
                    rx_valid   <= 1'b1;
                    bit_cnt    <= '0;
                    shift_pend <= 1'b0;
                    if (cs_s) begin
                        state <= IDLE;
                    end else begin
                        state    <= ACTIVE;
                        tx_shift <= load_val;
                        miso_r   <= load_val[DATA_WIDTH-1];
                        if (!tx_full) overrun <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Single-entry tx buffer; a load and an accept in the same clk refill it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            tx_full <= 1'b0;
            tx_buf  <= '0;
        end else begin
            if (load) tx_full <= 1'b0;
            if (accept) begin
                tx_full <= 1'b1;
                tx_buf  <= tx_data;
            end
        end
    end

    assign tx_ready = ~tx_full;
    assign miso_oe  = ~cs_s;
    assign miso     = miso_oe & miso_r;

endmodule
